ups_dac_arb: RTL

Arbiter and write scheduler for the shared dual-channel DAC. Two requesters, channel 0 and channel 1, post 12-bit setpoints with a single-cycle strobe. The block holds the newest value per channel, issues one write at a time to the DAC serial driver over a valid/ready handshake with a programmable inter-write gap, and pulses `ldac` once the queue drains so both outputs update together. It sits between the UPS controller's DAC outputs and the DAC serial driver.

---
 rtl/ups_pkg.sv | 14 +
 rtl/ups_dac_hold.sv | 78 +++++++
 rtl/ups_dac_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ups_pkg.sv
// Shared types for the UPS DAC write arbiter: FSM state encoding and channel IDs.
package ups_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_GAP   = 2'd2,
        ARB_LDAC  = 2'd3
    } arb_state_t;

    localparam logic DAC_CH0 = 1'b0;
    localparam logic DAC_CH1 = 1'b1;

endpackage

// File: rtl/ups_dac_hold.sv
// One-entry newest-wins holding register for a DAC channel, with pend flag.
// Overrun counter is present only when UPS_DAC_ARB_OVR_EN is defined.
module ups_dac_hold
    import ups_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dv,
    input  logic [DATA_W-1:0] din,
    input  logic              grant,
    output logic [DATA_W-1:0] dout,
    output logic              pend,
    output logic [CNT_W-1:0]  ovr_cnt
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              pend_q, pend_d;

    // A strobe landing on the grant edge refills the register; grant only clears when idle.
    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        if (flush) begin
            pend_d = 1'b0;
        end else if (dv) begin
            data_d = din;
            pend_d = 1'b1;
        end else if (grant) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign dout = data_q;
    assign pend = pend_q;

`ifdef UPS_DAC_ARB_OVR_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr;

    assign ovr = dv & pend_q & ~grant & ~flush;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (ovr && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovr_cnt = cnt_q;
`else
    assign ovr_cnt = '0;
`endif

endmodule

// File: rtl/ups_dac_arb.sv
// Round-robin write scheduler for the shared dual-channel DAC with inter-write gap and ldac.
// Optional overrun counters enabled by defining UPS_DAC_ARB_OVR_EN.
module ups_dac_arb
    import ups_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] ch0_data,
    input  logic              ch0_dv,
    input  logic [DATA_W-1:0] ch1_data,
    input  logic              ch1_dv,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_ch,
    output logic              dac_valid,
    input  logic              dac_ready,
    output logic              ldac,
    output logic              ch0_pend,
    output logic              ch1_pend,
    output logic [CNT_W-1:0]  ch0_ovr_cnt,
    output logic [CNT_W-1:0]  ch1_ovr_cnt
);

    localparam int unsigned       GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);

    arb_state_t        state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ch_q, ch_d;
    logic              grant0, grant1;
    logic [DATA_W-1:0] hold0_data, hold1_data;
    logic              any_pend;

    ups_dac_hold #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_hold0 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .dv      (ch0_dv),
        .din     (ch0_data),
        .grant   (grant0),
        .dout    (hold0_data),
        .pend    (ch0_pend),
        .ovr_cnt (ch0_ovr_cnt)
    );

    ups_dac_hold #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_hold1 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .dv      (ch1_dv),
        .din     (ch1_data),
        .grant   (grant1),
        .dout    (hold1_data),
        .pend    (ch1_pend),
        .ovr_cnt (ch1_ovr_cnt)
    );

    assign any_pend = ch0_pend | ch1_pend;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        last_d    = last_q;
        data_d    = data_q;
        ch_d      = ch_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        dac_valid = 1'b0;
        ldac      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_pend) begin
                    // On a tie, the channel that did not win last time goes first.
                    if (ch0_pend && (!ch1_pend || last_q == DAC_CH1)) begin
                        grant0 = 1'b1;
                        data_d = hold0_data;
                        ch_d   = DAC_CH0;
                        last_d = DAC_CH0;
                    end else begin
                        grant1 = 1'b1;
                        data_d = hold1_data;
                        ch_d   = DAC_CH1;
                        last_d = DAC_CH1;
                    end
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                dac_valid = 1'b1;
                if (dac_ready) begin
                    if (GAP_CYC > 0) begin
                        state_d = ARB_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = any_pend ? ARB_IDLE : ARB_LDAC;
                    end
                end
            end
            ARB_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = any_pend ? ARB_IDLE : ARB_LDAC;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ARB_LDAC: begin
                ldac    = 1'b1;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gap_q   <= '0;
            last_q  <= DAC_CH1;
            data_q  <= '0;
            ch_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    assign dac_data = data_q;
    assign dac_ch   = ch_q;

endmodule
